cic_iq_sched: RTL
=================

Name: cic_iq_sched

Overview:
- Sequences the two CIC decimators on the I and Q paths, one per channel.
- Detects each decimator's output strobe and pairs the I and Q samples.
- Queues the pairs in a small FIFO and hands them to the demodulator over a valid/ready handshake.
- Owns the CIC gain setting: a new setting is applied only at a sample-pair boundary, so I and Q never use mismatched gain.

Parameters:
- DW, 12, sample width of each CIC output and of out_i/out_q.
- GAIN_W, 8, width of the CIC gain control.
- GAIN_RST, 8'd1, gain driven after reset.
- FIFO_DEPTH, 4, pair FIFO entries (power of two, ≥2).
- PAIR_TIMEOUT, 64, max cycles between the I and Q strobes of one pair.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- i_dclk  in  1  I-channel CIC output clock (level; rising edge = new sample)
- i_data  in  DW  I-channel CIC output, signed
- q_dclk  in  1  Q-channel CIC output clock
- q_data  in  DW  Q-channel CIC output, signed
- cfg_wr  in  1  one-cycle config write strobe
- cfg_gain  in  GAIN_W  requested gain
- cfg_mute  in  1  requested mute
- cfg_clr  in  1  clears the sticky flags when cfg_wr=1
- gain_out  out  GAIN_W  gain to both CICs
- out_valid  out  1  pair available
- out_ready  in  1  consumer accepts
- out_i  out  DW  I sample, signed
- out_q  out  DW  Q sample, signed
- overflow  out  1  sticky: a pair was dropped because the FIFO was full
- pair_err  out  1  sticky: a pairing fault occurred (timeout or repeated strobe)

Behaviour:
- Reset: all registers asynchronously cleared.
  - gain_out=GAIN_RST, mute=0.
  - out_valid=0, out_i=out_q=0, overflow=pair_err=0, FIFO empty, FSM=IDLE.
- Reset asserted mid-operation discards any in-flight half-pair and all FIFO contents.
- Strobe detect: i_dclk and q_dclk are each registered once.
  - ev_i = i_dclk & ~i_dclk_q.
  - i_data is captured into hold_i on the ev_i cycle; Q is handled identically.
- FSM states and transitions:
  - IDLE:
    - ev_i&ev_q → PUSH.
    - ev_i only → HAVE_I.
    - ev_q only → HAVE_Q.
  - HAVE_I:
    - ev_q → PUSH.
    - ev_i again → overwrite hold_i, set pair_err, restart timer, stay.
    - Timer reaches PAIR_TIMEOUT-1 → set pair_err, go to IDLE; the half-pair is discarded.
  - HAVE_Q: symmetric to HAVE_I.
  - PUSH: one cycle.
    - Writes {hold_i,hold_q} to the FIFO, or {0,0} if mute is active.
    - If the FIFO is full, nothing is written and overflow is set.
    - If pending_gain_vld, gain_out ← pending_gain, mute ← pending_mute, pending_gain_vld cleared.
    - Next state: IDLE.
    - ev_i or ev_q occurring in PUSH is handled as if in IDLE: PUSH → HAVE_I/HAVE_Q/PUSH accordingly.
- Timer: counts from entry to HAVE_I/HAVE_Q; width clog2(PAIR_TIMEOUT).
- Latency: second strobe detected in cycle E → FIFO write at end of E+1 → out_valid=1 in E+2 if the FIFO was empty.
- FIFO:
  - Show-ahead: out_i/out_q are valid whenever out_valid=1 and remain stable until out_valid&out_ready.
  - Pop occurs on out_valid&out_ready.
  - Simultaneous push and pop when full: the pop frees a slot, so the push succeeds and overflow is not set.
  - Pointers wrap modulo FIFO_DEPTH; occupancy is counted 0..FIFO_DEPTH.
- Config:
  - cfg_wr latches pending_gain/pending_mute and sets pending_gain_vld.
  - A later cfg_wr before application overwrites the pending values.
  - If the FSM is in IDLE with no event on the cycle after cfg_wr, the values are applied on that cycle; otherwise they are applied at the next PUSH.
  - cfg_wr&cfg_clr clears overflow/pair_err. A set event in the same cycle wins.

Optional Feature:
- Macro: CIC_IQ_STATS_EN.
- When defined, adds these outputs, both cleared by reset and by cfg_wr&cfg_clr:
  - pair_cnt [15:0]: pairs written to the FIFO, wraps.
  - drop_cnt [15:0]: pairs dropped plus pairing faults, saturates at 16'hFFFF.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package cic_sched_pkg holds:
  - FSM state enum (IDLE, HAVE_I, HAVE_Q, PUSH).
  - Default DW/GAIN_W/GAIN_RST constants.
  - Pair struct {i, q}.
- One sub-module, cic_pair_fifo: parameterised show-ahead sync FIFO with full/empty and count, async active-high reset.

Test Plan:
- I strobe with i_data=12'h123, Q strobe 3 cycles later with q_data=12'hF00 → out_valid 2 cycles after the Q edge with out_i=12'h123, out_q=12'hF00; flags stay 0.
- Simultaneous I/Q edges, out_ready held 0, 5 pairs → first 4 queued, 5th dropped, overflow=1; then drain → 4 pairs delivered in order, out_valid=0.
- I edge, no Q for PAIR_TIMEOUT (64) cycles → pair_err=1, nothing queued; a following I+Q pair is delivered normally.
- cfg_wr with gain=8'd4 while in HAVE_I → gain_out stays 8'd1 until the PUSH cycle, then 8'd4. cfg_mute=1 → next pair is delivered as out_i=out_q=0.
- FIFO full with pop and push in the same cycle → no overflow; occupancy stays 4.
- Assert rst while in HAVE_Q with 2 entries queued → out_valid=0 immediately, gain_out=GAIN_RST; next clean pair is delivered first.

Source files
------------

// File: rtl/cic_sched_pkg.sv
// Shared types and defaults for the CIC I/Q pair scheduler.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
// Contents: FSM state enum, default widths/gain, default-width pair
// struct, saturating 16-bit increment used by the optional statistics.
package cic_sched_pkg;

  localparam int         DW_DEF       = 12;
  localparam int         GAIN_W_DEF   = 8;
  localparam logic [7:0] GAIN_RST_DEF = 8'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HAVE_I = 2'd1,
    HAVE_Q = 2'd2,
    PUSH   = 2'd3
  } state_t;

  // Default-width view of one I/Q pair as seen by the demodulator.
  typedef struct packed {
    logic [DW_DEF-1:0] i;
    logic [DW_DEF-1:0] q;
  } pair_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/cic_pair_fifo.sv
// Show-ahead synchronous FIFO holding I/Q pairs between scheduler and demodulator.
// Latency: a push is visible at head/~empty on the cycle after the write edge.
// Backpressure: push is refused when full unless a pop frees a slot in the same cycle.
// Ports: clk, rst (async, active-high); push/push_dat write side;
//        pop/head read side (head valid whenever empty=0); full, empty status.
module cic_pair_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4   // power of two, >= 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;   // occupancy 0..DEPTH
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);   // DEPTH is a power of two: natural wrap
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/cic_iq_sched.sv
// Pairs I/Q CIC decimator outputs, queues them, and owns the shared CIC gain.
// Latency: second strobe seen in cycle E -> FIFO write end of E+1 -> out_valid in E+2.
// Backpressure: out_valid/out_ready; a pair arriving at a full FIFO is dropped (overflow).
// Ports: clk, rst (async, active-high); i_dclk/i_data, q_dclk/q_data from the CICs;
//        cfg_wr/cfg_gain/cfg_mute/cfg_clr config; gain_out to both CICs;
//        out_valid/out_ready/out_i/out_q to the demodulator; sticky overflow, pair_err.
// Optional: define CIC_IQ_STATS_EN to add pair_cnt and drop_cnt statistics outputs.
module cic_iq_sched
  import cic_sched_pkg::*;
#(
  parameter int                DW           = DW_DEF,
  parameter int                GAIN_W       = GAIN_W_DEF,
  parameter logic [GAIN_W-1:0] GAIN_RST     = GAIN_W'(GAIN_RST_DEF),
  parameter int                FIFO_DEPTH   = 4,
  parameter int                PAIR_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_dclk,
  input  logic signed [DW-1:0] i_data,
  input  logic                 q_dclk,
  input  logic signed [DW-1:0] q_data,
  input  logic                 cfg_wr,
  input  logic [GAIN_W-1:0]    cfg_gain,
  input  logic                 cfg_mute,
  input  logic                 cfg_clr,
  output logic [GAIN_W-1:0]    gain_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_i,
  output logic signed [DW-1:0] out_q,
  output logic                 overflow,
`ifdef CIC_IQ_STATS_EN
  output logic [15:0]          pair_cnt,
  output logic [15:0]          drop_cnt,
`endif
  output logic                 pair_err
);

  localparam int TW = $clog2(PAIR_TIMEOUT);

  // Pair layout at the configured sample width.
  typedef struct packed {
    logic [DW-1:0] i;
    logic [DW-1:0] q;
  } dw_pair_t;

  // Strobe detection
  logic i_dclk_q;
  logic q_dclk_q;
  logic ev_i;
  logic ev_q;

  assign ev_i = i_dclk & ~i_dclk_q;
  assign ev_q = q_dclk & ~q_dclk_q;

  // Pairing state
  state_t        state;
  logic [TW-1:0] timer;
  logic [DW-1:0] hold_i;
  logic [DW-1:0] hold_q;
  logic          timeout;
  logic          pair_fault;

  // Config state
  logic [GAIN_W-1:0] pending_gain;
  logic              pending_mute;
  logic              pending_gain_vld;
  logic              mute;
  logic              cfg_wr_q;
  logic              apply_cfg;
  logic              flag_clr;

  // FIFO interface
  dw_pair_t fifo_din;
  dw_pair_t fifo_head;
  logic     fifo_push;
  logic     fifo_pop;
  logic     fifo_full;
  logic     fifo_empty;
  logic     drop;

  assign timeout = (timer == TW'(PAIR_TIMEOUT - 1));

  // A half-pair faults on a repeated strobe of its own channel or on timeout;
  // the partner strobe always completes the pair instead.
  assign pair_fault = ((state == HAVE_I) && !ev_q && (ev_i || timeout)) ||
                      ((state == HAVE_Q) && !ev_i && (ev_q || timeout));

  assign fifo_push = (state == PUSH);
  assign fifo_pop  = out_valid & out_ready;
  assign drop      = fifo_push & fifo_full & ~fifo_pop;
  assign flag_clr  = cfg_wr & cfg_clr;

  // Gain/mute only change on a pair boundary: a quiet IDLE cycle right after the
  // write, or the PUSH cycle that closes the current pair.
  assign apply_cfg = pending_gain_vld &
                     ((state == PUSH) ||
                      ((state == IDLE) && cfg_wr_q && !ev_i && !ev_q));

  always_comb begin
    fifo_din   = '0;
    fifo_din.i = mute ? '0 : hold_i;
    fifo_din.q = mute ? '0 : hold_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_dclk_q         <= 1'b0;
      q_dclk_q         <= 1'b0;
      hold_i           <= '0;
      hold_q           <= '0;
      state            <= IDLE;
      timer            <= '0;
      gain_out         <= GAIN_RST;
      mute             <= 1'b0;
      pending_gain     <= '0;
      pending_mute     <= 1'b0;
      pending_gain_vld <= 1'b0;
      cfg_wr_q         <= 1'b0;
      overflow         <= 1'b0;
      pair_err         <= 1'b0;
    end else begin
      i_dclk_q <= i_dclk;
      q_dclk_q <= q_dclk;
      cfg_wr_q <= cfg_wr;

      if (ev_i) hold_i <= i_data;
      if (ev_q) hold_q <= q_data;

      case (state)
        // PUSH lasts one cycle and otherwise behaves like IDLE for new strobes.
        IDLE, PUSH: begin
          timer <= '0;
          if (ev_i && ev_q)  state <= PUSH;
          else if (ev_i)     state <= HAVE_I;
          else if (ev_q)     state <= HAVE_Q;
          else               state <= IDLE;
        end
        HAVE_I: begin
          if (ev_q) begin
            state <= PUSH;
          end else if (ev_i) begin
            timer <= '0;            // newer I sample replaces the stale one
          end else if (timeout) begin
            state <= IDLE;          // half-pair abandoned
          end else begin
            timer <= timer + TW'(1);
          end
        end
        HAVE_Q: begin
          if (ev_i) begin
            state <= PUSH;
          end else if (ev_q) begin
            timer <= '0;
          end else if (timeout) begin
            state <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Sticky flags: a set in the same cycle as a clear wins.
      overflow <= (overflow & ~flag_clr) | drop;
      pair_err <= (pair_err & ~flag_clr) | pair_fault;

      if (apply_cfg) begin
        gain_out         <= pending_gain;
        mute             <= pending_mute;
        pending_gain_vld <= 1'b0;
      end
      // A write in the same cycle as an apply queues the new values behind it.
      if (cfg_wr) begin
        pending_gain     <= cfg_gain;
        pending_mute     <= cfg_mute;
        pending_gain_vld <= 1'b1;
      end
    end
  end

`ifdef CIC_IQ_STATS_EN
  logic pair_written;

  assign pair_written = fifo_push & ~drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      pair_cnt <= (flag_clr ? 16'd0 : pair_cnt) + 16'(pair_written);
      drop_cnt <= sat_inc16(flag_clr ? 16'd0 : drop_cnt, drop | pair_fault);
    end
  end
`endif

  cic_pair_fifo #(
    .W     (2 * DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (fifo_din),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_i     = fifo_head.i;
  assign out_q     = fifo_head.q;

endmodule
